sonar_ping_scheduler: RTL and testbench

- Parametrised successor to the fixed single-angle ping loop.
- Sequences repeated sonar pings: burst window, ringing blanking window, listen window, one-cycle report.
- Steps the beam angle either fixed or across a sweep, and strobes ADC sampling during listen.
- Thresholds the aggregated receive magnitude and reports time of flight per angle. Sits between the transmit/receive beamformers and the range/display logic.

---
 rtl/sonar_pkg.sv | 34 +++
 rtl/beam_angle_sequencer.sv | 62 ++++++
 rtl/sonar_ping_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_sonar_ping_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// sonar_pkg
//   Shared definitions for the sonar ping scheduler and the beamformers that
//   sit on either side of it: the scheduler state encoding, the signed beam
//   angle type and the default ping timing constants.
//
//   Optional feature macro used by the scheduler: SONAR_PEAK_TRACK_EN
package sonar_pkg;

  // Scheduler phases of one ping, in the order they occur.
  typedef enum logic [2:0] {
    IDLE,
    BURST,
    BLANK,
    LISTEN,
    REPORT
  } state_t;

  // Default beam angle width and the matching signed angle type (degrees).
  localparam int ANGLE_WIDTH_DEF = 8;
  typedef logic signed [ANGLE_WIDTH_DEF-1:0] angle_t;

  // Default ping timing, shared with the transmit/receive beamformers.
  localparam int PERIOD_CYCLES_DEF = 16777216;
  localparam int BURST_CYCLES_DEF  = 524288;
  localparam int BLANK_CYCLES_DEF  = 65536;
  localparam int SAMPLE_PERIOD_DEF = 100;
  localparam int DATA_WIDTH_DEF    = 16;

  // Default sweep range and step (degrees).
  localparam int ANGLE_MIN_DEF  = -30;
  localparam int ANGLE_MAX_DEF  = 30;
  localparam int ANGLE_STEP_DEF = 10;

endpackage

// File: rtl/beam_angle_sequencer.sv
// beam_angle_sequencer
//   Holds the beam angle for the current ping. On every load pulse (the
//   clock edge that enters BURST) it picks the new angle: the fixed angle in
//   fixed mode, otherwise the next sweep angle. A sweep restarts at ANGLE_MIN
//   when it is entered from idle or from a fixed-mode ping, and wraps back to
//   ANGLE_MIN once the step would pass ANGLE_MAX.
//
// Ports
//   clk_in       system clock
//   rst_n        asynchronous active-low reset
//   load         one-cycle strobe, latch a new angle
//   from_idle    load comes from the idle state (restart a sweep)
//   sweep_mode   0 = fixed angle, 1 = sweep
//   fixed_angle  signed angle used in fixed mode
//   angle        registered signed angle, constant between loads
module beam_angle_sequencer
  import sonar_pkg::*;
#(
  parameter int ANGLE_WIDTH = ANGLE_WIDTH_DEF,
  parameter int ANGLE_MIN   = ANGLE_MIN_DEF,
  parameter int ANGLE_MAX   = ANGLE_MAX_DEF,
  parameter int ANGLE_STEP  = ANGLE_STEP_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          from_idle,
  input  logic                          sweep_mode,
  input  logic signed [ANGLE_WIDTH-1:0] fixed_angle,
  output logic signed [ANGLE_WIDTH-1:0] angle
);

  logic                          last_sweep;
  int                            stepped;
  logic signed [ANGLE_WIDTH-1:0] next_angle;

  // Next angle selection. The step is done in int so that a step past the
  // top of the angle range cannot overflow before the wrap test.
  always_comb begin
    stepped = int'(angle) + ANGLE_STEP;
    if (!sweep_mode) begin
      next_angle = fixed_angle;
    end else if (from_idle || !last_sweep || (stepped > ANGLE_MAX)) begin
      next_angle = ANGLE_WIDTH'(ANGLE_MIN);
    end else begin
      next_angle = ANGLE_WIDTH'(stepped);
    end
  end

  // Angle register plus a record of whether the previous ping was a sweep
  // ping, which decides between continuing and restarting the sweep.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      angle      <= '0;
      last_sweep <= 1'b0;
    end else if (load) begin
      angle      <= next_angle;
      last_sweep <= sweep_mode;
    end
  end

endmodule

// File: rtl/sonar_ping_scheduler.sv
// sonar_ping_scheduler
//   Sequences repeated sonar pings: a transmit burst, a blanking window that
//   hides transmitter ringing, a listen window during which the ADC is
//   strobed, and a single report cycle. Each ping's beam angle comes from
//   beam_angle_sequencer. The received magnitude is thresholded during
//   listen and the time of flight (period count at detection) is reported.
//
//   Optional feature macro: SONAR_PEAK_TRACK_EN
//     Defined   - listen tracks the largest valid sample (earliest wins on a
//                 tie); tof_out is its count, peak_out its value, and
//                 echo_found_out is peak >= threshold.
//     Undefined - first sample at or above threshold is the echo; no
//                 peak_out port.
//
// Ports
//   clk_in              system clock
//   rst_n               asynchronous active-low reset
//   enable_in           run pings while high
//   sweep_mode_in       0 = fixed angle, 1 = sweep
//   fixed_angle_in      signed angle used in fixed mode
//   threshold_in        echo threshold
//   sample_data_in      aggregated receive magnitude
//   sample_valid_in     sample_data_in qualifier
//   burst_start_out     one-cycle pulse on the first burst cycle
//   burst_active_out    high throughout the burst window
//   beam_angle_out      signed angle for the current ping
//   sample_trigger_out  ADC conversion strobe
//   result_valid_out    one-cycle pulse in the report cycle
//   echo_found_out      echo detected in the last ping
//   tof_out             period count at detection
//   result_angle_out    angle of the last reported ping
//   peak_out            peak sample of the last ping (peak tracking only)
module sonar_ping_scheduler
  import sonar_pkg::*;
#(
  parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
  parameter int BURST_CYCLES  = BURST_CYCLES_DEF,
  parameter int BLANK_CYCLES  = BLANK_CYCLES_DEF,
  parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ANGLE_WIDTH   = ANGLE_WIDTH_DEF,
  parameter int ANGLE_MIN     = ANGLE_MIN_DEF,
  parameter int ANGLE_MAX     = ANGLE_MAX_DEF,
  parameter int ANGLE_STEP    = ANGLE_STEP_DEF,
  localparam int CW           = $clog2(PERIOD_CYCLES)
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          enable_in,
  input  logic                          sweep_mode_in,
  input  logic signed [ANGLE_WIDTH-1:0] fixed_angle_in,
  input  logic [DATA_WIDTH-1:0]         threshold_in,
  input  logic [DATA_WIDTH-1:0]         sample_data_in,
  input  logic                          sample_valid_in,
  output logic                          burst_start_out,
  output logic                          burst_active_out,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                          sample_trigger_out,
  output logic                          result_valid_out,
  output logic                          echo_found_out,
  output logic [CW-1:0]                 tof_out,
  output logic signed [ANGLE_WIDTH-1:0] result_angle_out
`ifdef SONAR_PEAK_TRACK_EN
 ,output logic [DATA_WIDTH-1:0]         peak_out
`endif
);

  // Period counts at which each window ends.
  localparam logic [CW-1:0] LAST_BURST  = CW'(BURST_CYCLES - 1);
  localparam logic [CW-1:0] LAST_BLANK  = CW'(BURST_CYCLES + BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LAST_LISTEN = CW'(PERIOD_CYCLES - 2);

  // Sample strobe spacing counter.
  localparam int            SW      = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [SW-1:0] SP_LAST = SW'(SAMPLE_PERIOD - 1);

  state_t                  state;
  logic [CW-1:0]           count;
  logic [SW-1:0]           sample_cnt;
  logic [DATA_WIDTH-1:0]   thr_r;
  logic                    hit_r;
  logic [CW-1:0]           mark_r;

  logic                    start_ping;
  logic                    from_idle;
  logic                    listen_valid;
  logic                    take;
  logic                    hit_next;
  logic [CW-1:0]           mark_next;
  logic                    found_report;
`ifdef SONAR_PEAK_TRACK_EN
  logic [DATA_WIDTH-1:0]   peak_r;
  logic [DATA_WIDTH-1:0]   peak_next;
`endif

  // A new ping starts from idle or straight out of a report cycle.
  assign start_ping = enable_in && ((state == IDLE) || (state == REPORT));
  assign from_idle  = (state == IDLE);

  beam_angle_sequencer #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ANGLE_MIN   (ANGLE_MIN),
    .ANGLE_MAX   (ANGLE_MAX),
    .ANGLE_STEP  (ANGLE_STEP)
  ) u_angle (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .load        (start_ping),
    .from_idle   (from_idle),
    .sweep_mode  (sweep_mode_in),
    .fixed_angle (fixed_angle_in),
    .angle       (beam_angle_out)
  );

  // Echo detector next-state. It includes the current cycle's sample so a
  // sample on the last listen cycle still reaches the report. Samples are
  // only considered in LISTEN; everywhere else they are ignored.
  always_comb begin
    listen_valid = (state == LISTEN) && sample_valid_in;
`ifdef SONAR_PEAK_TRACK_EN
    // Strictly greater keeps the earlier sample on a tie.
    take         = listen_valid && (!hit_r || (sample_data_in > peak_r));
    hit_next     = hit_r | listen_valid;
    peak_next    = take ? sample_data_in : peak_r;
    mark_next    = take ? count : mark_r;
    found_report = hit_next && (peak_next >= thr_r);
`else
    take         = listen_valid && !hit_r && (sample_data_in >= thr_r);
    hit_next     = hit_r | take;
    mark_next    = take ? count : mark_r;
    found_report = hit_next;
`endif
  end

  // Ping scheduler FSM with period counter, ADC strobe spacing, detector
  // state and all registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      count              <= '0;
      sample_cnt         <= '0;
      thr_r              <= '0;
      hit_r              <= 1'b0;
      mark_r             <= '0;
      burst_start_out    <= 1'b0;
      burst_active_out   <= 1'b0;
      sample_trigger_out <= 1'b0;
      result_valid_out   <= 1'b0;
      echo_found_out     <= 1'b0;
      tof_out            <= '0;
      result_angle_out   <= '0;
`ifdef SONAR_PEAK_TRACK_EN
      peak_r             <= '0;
      peak_out           <= '0;
`endif
    end else begin
      burst_start_out    <= 1'b0;
      sample_trigger_out <= 1'b0;
      result_valid_out   <= 1'b0;
      unique case (state)
        IDLE, REPORT: begin
          count <= '0;
          if (start_ping) begin
            state            <= BURST;
            burst_start_out  <= 1'b1;
            burst_active_out <= 1'b1;
            thr_r            <= threshold_in;
            hit_r            <= 1'b0;
            mark_r           <= '0;
`ifdef SONAR_PEAK_TRACK_EN
            peak_r           <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        BURST: begin
          count <= count + 1'b1;
          if (count == LAST_BURST) begin
            state            <= BLANK;
            burst_active_out <= 1'b0;
          end
        end
        BLANK: begin
          count <= count + 1'b1;
          if (count == LAST_BLANK) begin
            state              <= LISTEN;
            sample_trigger_out <= 1'b1;
            sample_cnt         <= '0;
          end
        end
        LISTEN: begin
          count  <= count + 1'b1;
          hit_r  <= hit_next;
          mark_r <= mark_next;
`ifdef SONAR_PEAK_TRACK_EN
          peak_r <= peak_next;
`endif
          if (count == LAST_LISTEN) begin
            state            <= REPORT;
            result_valid_out <= 1'b1;
            echo_found_out   <= found_report;
            tof_out          <= found_report ? mark_next : '0;
            result_angle_out <= beam_angle_out;
`ifdef SONAR_PEAK_TRACK_EN
            peak_out         <= peak_next;
`endif
          end else if (sample_cnt == SP_LAST) begin
            sample_trigger_out <= 1'b1;
            sample_cnt         <= '0;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_ping_scheduler.sv
// tb_sonar_ping_scheduler
//   Directed bench for sonar_ping_scheduler with a short ping
//   (PERIOD 1000, BURST 100, BLANK 50, SAMPLE_PERIOD 10). Every cycle of each
//   ping is compared against the expected window timing, and each report
//   against hand-computed echo results. Build with SONAR_PEAK_TRACK_EN
//   defined to exercise peak tracking.
module tb_sonar_ping_scheduler;

  localparam int PERIOD = 1000;
  localparam int BURST  = 100;
  localparam int BLANK  = 50;
  localparam int SP     = 10;
  localparam int TW     = $clog2(PERIOD);
`ifdef SONAR_PEAK_TRACK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic              enable_in;
  logic              sweep_mode_in;
  logic signed [7:0] fixed_angle_in;
  logic [15:0]       threshold_in;
  logic [15:0]       sample_data_in;
  logic              sample_valid_in;
  logic              burst_start_out;
  logic              burst_active_out;
  logic signed [7:0] beam_angle_out;
  logic              sample_trigger_out;
  logic              result_valid_out;
  logic              echo_found_out;
  logic [TW-1:0]     tof_out;
  logic signed [7:0] result_angle_out;
`ifdef SONAR_PEAK_TRACK_EN
  logic [15:0]       peak_out;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-ping sample script and the input changes applied at count 500.
  int                samp_pos [4];
  int                samp_dat [4];
  logic              mid_do;
  logic              mid_en;
  logic              mid_sweep;
  logic signed [7:0] mid_fixed;
  logic [15:0]       mid_thr;

  always #5 clk_in = ~clk_in;

  sonar_ping_scheduler #(
    .PERIOD_CYCLES (PERIOD),
    .BURST_CYCLES  (BURST),
    .BLANK_CYCLES  (BLANK),
    .SAMPLE_PERIOD (SP),
    .DATA_WIDTH    (16),
    .ANGLE_WIDTH   (8),
    .ANGLE_MIN     (-30),
    .ANGLE_MAX     (30),
    .ANGLE_STEP    (10)
  ) dut (
    .clk_in             (clk_in),
    .rst_n              (rst_n),
    .enable_in          (enable_in),
    .sweep_mode_in      (sweep_mode_in),
    .fixed_angle_in     (fixed_angle_in),
    .threshold_in       (threshold_in),
    .sample_data_in     (sample_data_in),
    .sample_valid_in    (sample_valid_in),
    .burst_start_out    (burst_start_out),
    .burst_active_out   (burst_active_out),
    .beam_angle_out     (beam_angle_out),
    .sample_trigger_out (sample_trigger_out),
    .result_valid_out   (result_valid_out),
    .echo_found_out     (echo_found_out),
    .tof_out            (tof_out),
    .result_angle_out   (result_angle_out)
`ifdef SONAR_PEAK_TRACK_EN
   ,.peak_out           (peak_out)
`endif
  );

  // Advance one clock; leave 1 time unit after the edge for sampling/driving.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data);
    sample_valid_in = valid;
    sample_data_in  = data;
  endtask

  task automatic setSamples(input int p0, input int d0, input int p1, input int d1,
                            input int p2, input int d2, input int p3, input int d3);
    samp_pos[0] = p0; samp_dat[0] = d0;
    samp_pos[1] = p1; samp_dat[1] = d1;
    samp_pos[2] = p2; samp_dat[2] = d2;
    samp_pos[3] = p3; samp_dat[3] = d3;
  endtask

  // Bounded wait for the first burst cycle.
  task automatic waitBurst(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (burst_start_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("burst_wait", 32'(seen), 32'sd1);
  endtask

  // Runs one full ping starting at count 0 and checks every cycle.
  task automatic runPing(input int exp_angle, input logic exp_found,
                         input int exp_tof, input int exp_peak);
    logic        v;
    logic [15:0] d;
    for (int c = 0; c < PERIOD; c++) begin
      v = 1'b0;
      d = 16'd0;
      for (int k = 0; k < 4; k++) begin
        if (samp_pos[k] == c) begin
          v = 1'b1;
          d = 16'(samp_dat[k]);
        end
      end
      applyStimulus(v, d);
      if (mid_do && (c == 500)) begin
        enable_in      = mid_en;
        sweep_mode_in  = mid_sweep;
        fixed_angle_in = mid_fixed;
        threshold_in   = mid_thr;
      end
      checkOutput("burst_start", 32'(burst_start_out), 32'(c == 0));
      checkOutput("burst_active", 32'(burst_active_out), 32'(c < BURST));
      checkOutput("sample_trigger", 32'(sample_trigger_out),
                  32'((c >= BURST + BLANK) && (c <= PERIOD - 2) &&
                      (((c - BURST - BLANK) % SP) == 0)));
      checkOutput("result_valid", 32'(result_valid_out), 32'(c == PERIOD - 1));
      checkOutput("beam_angle", 32'(beam_angle_out), exp_angle);
      if (c == PERIOD - 1) begin
        checkOutput("echo_found", 32'(echo_found_out), 32'(exp_found));
        checkOutput("tof", 32'(tof_out), exp_tof);
        checkOutput("result_angle", 32'(result_angle_out), exp_angle);
`ifdef SONAR_PEAK_TRACK_EN
        checkOutput("peak", 32'(peak_out), exp_peak);
`endif
      end
      tick();
    end
    applyStimulus(1'b0, 16'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_burst_start"}, 32'(burst_start_out), 32'sd0);
    checkOutput({tag, "_burst_active"}, 32'(burst_active_out), 32'sd0);
    checkOutput({tag, "_beam_angle"}, 32'(beam_angle_out), 32'sd0);
    checkOutput({tag, "_sample_trigger"}, 32'(sample_trigger_out), 32'sd0);
    checkOutput({tag, "_result_valid"}, 32'(result_valid_out), 32'sd0);
    checkOutput({tag, "_echo_found"}, 32'(echo_found_out), 32'sd0);
    checkOutput({tag, "_tof"}, 32'(tof_out), 32'sd0);
    checkOutput({tag, "_result_angle"}, 32'(result_angle_out), 32'sd0);
`ifdef SONAR_PEAK_TRACK_EN
    checkOutput({tag, "_peak"}, 32'(peak_out), 32'sd0);
`endif
  endtask

  initial begin
    rst_n          = 1'b0;
    enable_in      = 1'b0;
    sweep_mode_in  = 1'b0;
    fixed_angle_in = 8'sd0;
    threshold_in   = 16'd0;
    mid_do         = 1'b0;
    mid_en         = 1'b1;
    mid_sweep      = 1'b0;
    mid_fixed      = 8'sd0;
    mid_thr        = 16'd0;
    applyStimulus(1'b0, 16'd0);
    setSamples(-1, 0, -1, 0, -1, 0, -1, 0);
    repeat (3) tick();
    checkAllZero("reset");

    rst_n = 1'b1;
    tick();
    checkOutput("idle_no_burst", 32'(burst_start_out), 32'sd0);

    // Fixed angle 5; burst-window sample ignored, first crossing at 300.
    $display("[TB] fixed-angle ping with echo");
    fixed_angle_in = 8'sd5;
    threshold_in   = 16'd5000;
    enable_in      = 1'b1;
    waitBurst(5);
    setSamples(50, 9000, 200, 4999, 300, 6000, 400, 9000);
    runPing(5, 1'b1, PK ? 400 : 300, 9000);

    // Only blank/report samples cross; a live threshold change to 0 and a
    // switch to sweep mode mid-ping must not affect this ping.
    $display("[TB] blanking sample only, mid-ping input changes");
    setSamples(120, 8000, 600, 100, 999, 9000, -1, 0);
    mid_do = 1'b1; mid_en = 1'b1; mid_sweep = 1'b1; mid_fixed = 8'sd7; mid_thr = 16'd0;
    runPing(5, 1'b0, 0, 100);

    // First sweep ping from fixed mode, threshold 0: first valid sample wins.
    $display("[TB] sweep pings");
    setSamples(160, 3, -1, 0, -1, 0, -1, 0);
    mid_thr = 16'd5000;
    runPing(-30, 1'b1, 160, 3);
    mid_do = 1'b0;
    setSamples(200, 5500, 400, 7000, 500, 7000, -1, 0);
    runPing(-20, 1'b1, PK ? 400 : 200, 7000);
    setSamples(-1, 0, -1, 0, -1, 0, -1, 0);
    runPing(-10, 1'b0, 0, 0);
    runPing(0, 1'b0, 0, 0);
    runPing(10, 1'b0, 0, 0);
    runPing(20, 1'b0, 0, 0);
    runPing(30, 1'b0, 0, 0);

    // Wrapped ping; enable dropped halfway, ping still completes.
    mid_do = 1'b1; mid_en = 1'b0; mid_sweep = 1'b1; mid_fixed = 8'sd7; mid_thr = 16'd5000;
    runPing(-30, 1'b0, 0, 0);
    mid_do = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checkOutput("idle_burst_start", 32'(burst_start_out), 32'sd0);
      checkOutput("idle_burst_active", 32'(burst_active_out), 32'sd0);
      tick();
    end
    checkOutput("idle_result_angle", 32'(result_angle_out), -30);

    // Sweep restarts from idle, then reset at count 500 of the third ping.
    $display("[TB] restart from idle and mid-ping reset");
    enable_in = 1'b1;
    waitBurst(5);
    runPing(-30, 1'b0, 0, 0);
    runPing(-20, 1'b0, 0, 0);
    repeat (500) tick();
    checkOutput("pre_reset_trigger", 32'(sample_trigger_out), 32'sd1);
    checkOutput("pre_reset_angle", 32'(beam_angle_out), -10);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    waitBurst(5);
    checkOutput("rearm_burst_active", 32'(burst_active_out), 32'sd1);
    checkOutput("rearm_angle", 32'(beam_angle_out), -30);
    tick();
    checkOutput("rearm_start_pulse", 32'(burst_start_out), 32'sd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
